// File: rtl/fake_hilbert_pkg.sv
// rtl/fake_hilbert_pkg.sv - shared phase encoding and default width for fake_hilbert
package fake_hilbert_pkg;

    // Default bit width of the input sample and of each output component
    localparam int DEFAULT_WIDTH = 1;

    // Pairing phase: which half of the complex pair the next accepted sample fills
    typedef enum logic {
        PHASE_RE = 1'b0,
        PHASE_IM = 1'b1
    } phase_t;

    // Advance the pairing phase by one accepted sample
    function automatic phase_t next_phase(input phase_t cur);
        return (cur == PHASE_RE) ? PHASE_IM : PHASE_RE;
    endfunction

endpackage

// File: rtl/hilbert_pair.sv
// rtl/hilbert_pair.sv - pairs consecutive accepted samples into registered (re, im) outputs
module hilbert_pair
    import fake_hilbert_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             strobe,
    input  logic [WIDTH-1:0] signal,
    input  logic             invert,
    output logic             complete,
    output logic             valid,
    output logic [WIDTH-1:0] re,
    output logic [WIDTH-1:0] im
);

    phase_t           phase;
    logic [WIDTH-1:0] hold;
    logic             accept;

    // A sample only counts while running; strobes during disable are dropped
    assign accept   = enable & strobe;
    // The accepted sample closes a pair when it lands in the imaginary slot
    assign complete = accept && (phase == PHASE_IM);

    // Phase toggles per accepted sample; disable forces the next sample to be real
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= PHASE_RE;
        end else if (!enable) begin
            phase <= PHASE_RE;
        end else if (accept) begin
            phase <= next_phase(phase);
        end
    end

    // Real half of the pair waits here until its imaginary partner arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
        end else if (accept && (phase == PHASE_RE)) begin
            hold <= signal;
        end
    end

    // Output pair loads once per completed pair and otherwise holds; valid is a one-clock pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            re    <= '0;
            im    <= '0;
        end else begin
            valid <= complete;
            if (complete) begin
                re <= invert ? ~hold : hold;
                im <= invert ? ~signal : signal;
            end
        end
    end

endmodule

// File: rtl/fake_hilbert.sv
// rtl/fake_hilbert.sv - quarter-period-shift complex pairing top; optional FAKE_HILBERT_SIGN_FLIP_EN
module fake_hilbert
    import fake_hilbert_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             strobe_i,
    input  logic [WIDTH-1:0] signal_i,
    output logic             locked_o,
    output logic             strobe_o,
    output logic             framed_o,
    output logic [WIDTH-1:0] sig_re_o,
    output logic [WIDTH-1:0] sig_im_o
);

    logic complete;
    logic invert;
    logic locked;
    logic framed;

    hilbert_pair #(
        .WIDTH (WIDTH)
    ) u_pair (
        .clk      (clock_i),
        .rst      (reset_i),
        .enable   (enable_i),
        .strobe   (strobe_i),
        .signal   (signal_i),
        .invert   (invert),
        .complete (complete),
        .valid    (strobe_o),
        .re       (sig_re_o),
        .im       (sig_im_o)
    );

`ifdef FAKE_HILBERT_SIGN_FLIP_EN
    logic flip;

    // Alternate sign on every completed pair since enable rose, giving I,Q,-I,-Q
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            flip <= 1'b0;
        end else if (!enable_i) begin
            flip <= 1'b0;
        end else if (complete) begin
            flip <= ~flip;
        end
    end

    assign invert = flip;
`else
    assign invert = 1'b0;
`endif

    // Lock rises with the first completed pair and holds until enable drops
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            locked <= 1'b0;
        end else if (!enable_i) begin
            locked <= 1'b0;
        end else if (complete) begin
            locked <= 1'b1;
        end
    end

    // Frame marker accompanies only the pair that establishes lock
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            framed <= 1'b0;
        end else if (!enable_i) begin
            framed <= 1'b0;
        end else begin
            framed <= complete & ~locked;
        end
    end

    assign locked_o = locked;
    assign framed_o = framed;

endmodule

// File: tb/tb_fake_hilbert.sv
// tb/tb_fake_hilbert.sv - directed self-checking bench for fake_hilbert
module tb_fake_hilbert;

`ifdef FAKE_HILBERT_SIGN_FLIP_EN
    localparam bit FLIP = 1'b1;
`else
    localparam bit FLIP = 1'b0;
`endif

    logic clock_i  = 1'b0;
    logic reset_i  = 1'b1;
    logic enable_i = 1'b0;
    logic strobe_i = 1'b0;
    logic [0:0] signal_i = 1'b0;
    logic locked_o;
    logic strobe_o;
    logic framed_o;
    logic [0:0] sig_re_o;
    logic [0:0] sig_im_o;

    int checks = 0;
    int errors = 0;

    fake_hilbert #(
        .WIDTH (1)
    ) u_dut (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .enable_i (enable_i),
        .strobe_i (strobe_i),
        .signal_i (signal_i),
        .locked_o (locked_o),
        .strobe_o (strobe_o),
        .framed_o (framed_o),
        .sig_re_o (sig_re_o),
        .sig_im_o (sig_im_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (locked,strobe,framed,re,im)", tag, got[4:0], exp[4:0]);
        end
    endtask

    task automatic exp_out(input string tag, input logic l, input logic s, input logic f,
                           input logic r, input logic i);
        check(tag, {3'b000, locked_o, strobe_o, framed_o, sig_re_o, sig_im_o},
                   {3'b000, l, s, f, r, i});
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic send(input logic s);
        strobe_i = 1'b1;
        signal_i = s;
        tick();
        strobe_i = 1'b0;
    endtask

    initial begin
        // Reset held while strobe toggles: everything stays zero
        enable_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            strobe_i = k[0];
            signal_i = 1'b1;
            tick();
            exp_out("reset_hold", 0, 0, 0, 0, 0);
        end
        reset_i  = 1'b0;
        strobe_i = 1'b0;
        send(1'b1);
        exp_out("post_reset_half", 0, 0, 0, 0, 0);
        tick();
        exp_out("post_reset_idle", 0, 0, 0, 0, 0);

        // Fresh enable, samples 1,0,1,1
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        send(1'b1);
        exp_out("p1_first_half", 0, 0, 0, 0, 0);
        send(1'b0);
        exp_out("p1_pulse1", 1, 1, 1, 1, 0);
        send(1'b1);
        exp_out("p1_hold", 1, 0, 0, 1, 0);
        send(1'b1);
        exp_out("p1_pulse2", 1, 1, 0, 1 ^ FLIP, 1 ^ FLIP);
        tick();
        exp_out("p1_after", 1, 0, 0, 1 ^ FLIP, 1 ^ FLIP);

        // Half pair discarded by enable drop
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        send(1'b1);
        enable_i = 1'b0;
        tick();
        exp_out("drop_cleared", 0, 0, 0, 1 ^ FLIP, 1 ^ FLIP);
        enable_i = 1'b1;
        send(1'b0);
        exp_out("drop_no_stale", 0, 0, 0, 1 ^ FLIP, 1 ^ FLIP);
        send(1'b1);
        exp_out("drop_pair", 1, 1, 1, 0, 1);

        // Strobes while disabled are ignored
        enable_i = 1'b0;
        strobe_i = 1'b1;
        signal_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_out("disabled_strobe", 0, 0, 0, 0, 1);
        end
        strobe_i = 1'b0;

        // Back-to-back strobes for 6 cycles: samples 1,0,0,1,1,1
        enable_i = 1'b1;
        strobe_i = 1'b1;
        signal_i = 1'b1; tick(); exp_out("b2b_c0", 0, 0, 0, 0, 1);
        signal_i = 1'b0; tick(); exp_out("b2b_c1", 1, 1, 1, 1, 0);
        signal_i = 1'b0; tick(); exp_out("b2b_c2", 1, 0, 0, 1, 0);
        signal_i = 1'b1; tick(); exp_out("b2b_c3", 1, 1, 0, 0 ^ FLIP, 1 ^ FLIP);
        signal_i = 1'b1; tick(); exp_out("b2b_c4", 1, 0, 0, 0 ^ FLIP, 1 ^ FLIP);
        signal_i = 1'b1; tick(); exp_out("b2b_c5", 1, 1, 0, 1, 1);
        strobe_i = 1'b0;
        tick();
        exp_out("b2b_idle", 1, 0, 0, 1, 1);

        // Samples 1,0,1,0 after fresh enable: sign flip shows on second output
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        send(1'b1);
        send(1'b0);
        exp_out("flip_out1", 1, 1, 1, 1, 0);
        send(1'b1);
        send(1'b0);
        exp_out("flip_out2", 1, 1, 0, 1 ^ FLIP, 0 ^ FLIP);

        // Asynchronous reset mid-pair, then behaves like a fresh enable
        send(1'b1);
        reset_i = 1'b1;
        #1;
        exp_out("async_reset", 0, 0, 0, 0, 0);
        tick();
        reset_i = 1'b0;
        send(1'b0);
        exp_out("rst_half", 0, 0, 0, 0, 0);
        send(1'b1);
        exp_out("rst_pair", 1, 1, 1, 0, 1);
        tick();
        exp_out("rst_after", 1, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
